// File: rtl/key_pkg.sv
// key_pkg: scan-code tables and event class encoding shared with the application FSMs
package key_pkg;
   localparam logic [1:0] CLS_DIGIT = 2'd0;
   localparam logic [1:0] CLS_ENTER = 2'd1;
   localparam logic [1:0] CLS_SPACE = 2'd2;
   localparam logic [1:0] CLS_OTHER = 2'd3;
   localparam logic [7:0] ENTER_CODE = 8'h5A;
   localparam logic [7:0] SPACE_CODE = 8'h29;
   localparam logic [7:0] TOP_ROW [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] KEYPAD [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
   localparam logic [14:0] EMPTY_EVENT = {CLS_DIGIT, 4'hF, 9'h000};
endpackage

// File: rtl/key_event_queue_if.sv
// key_event_queue_if: decoder-side strobe inputs and consumer-side FIFO head/pop signals
interface key_event_queue_if #(parameter int DEPTH = 8);
   localparam int CW = $clog2(DEPTH) + 1;
   logic key_valid;
   logic [8:0] last_change;
   logic key_is_down;
   logic ev_pop;
   logic ev_valid;
   logic [1:0] ev_class;
   logic [3:0] ev_digit;
   logic [8:0] ev_code;
   logic [CW-1:0] count;
   logic overflow;
   logic clr_ovf;
   modport master(output key_valid, last_change, key_is_down, ev_pop, clr_ovf,
                  input ev_valid, ev_class, ev_digit, ev_code, count, overflow);
   modport slave(input key_valid, last_change, key_is_down, ev_pop, clr_ovf,
                 output ev_valid, ev_class, ev_digit, ev_code, count, overflow);
endinterface

// File: rtl/key_event_queue_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with explicit occupancy counter
module sync_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 8,
   parameter logic [WIDTH-1:0] EMPTY_WORD = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == FULL_CNT;
   assign do_pop = pop && !empty;
   // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign rdata = empty ? EMPTY_WORD : mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: classifies make codes, filters breaks/repeats and queues events FWFT
module key_event_queue
   import key_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int FILTER_REPEAT = 1,
   parameter int KEEP_OTHER = 0
) (
   input logic clk,
   input logic rst,
   key_event_queue_if.slave bus
);
   logic [1:0] cls;
   logic [3:0] dig;
   logic held_valid, match, make, accept, push, full, empty;
   logic [8:0] held_code;
   logic [14:0] head;
   always_comb begin
      cls = bus.last_change[8] ? CLS_OTHER :
            bus.last_change[7:0] == ENTER_CODE ? CLS_ENTER :
            bus.last_change[7:0] == SPACE_CODE ? CLS_SPACE : CLS_OTHER;
      dig = 4'hF;
      for (int i = 0; i < 10; i++)
         if (!bus.last_change[8] && (bus.last_change[7:0] == TOP_ROW[i] || bus.last_change[7:0] == KEYPAD[i])) begin
            cls = CLS_DIGIT;
            dig = 4'(i);
         end
   end
   assign match = held_valid && bus.last_change == held_code;
   assign make = bus.key_valid && bus.key_is_down;
   assign accept = make && !(FILTER_REPEAT != 0 && match);
   assign push = accept && (KEEP_OTHER != 0 || cls != CLS_OTHER);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         held_valid <= 1'b0;
         held_code <= '0;
         bus.overflow <= 1'b0;
      end else begin
         if (accept) begin
            held_valid <= 1'b1;
            held_code <= bus.last_change;
         end else if (bus.key_valid && !bus.key_is_down && match) held_valid <= 1'b0;
         // full implies non-empty, so ev_pop alone decides whether a slot frees
         bus.overflow <= (push && full && !bus.ev_pop) ? 1'b1 : bus.clr_ovf ? 1'b0 : bus.overflow;
      end
   sync_fifo #(.WIDTH(15), .DEPTH(DEPTH), .EMPTY_WORD(EMPTY_EVENT)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(bus.ev_pop),
      .wdata({cls, dig, bus.last_change}),
      .rdata(head),
      .full(full),
      .empty(empty),
      .count(bus.count)
   );
   assign bus.ev_valid = !empty;
   assign bus.ev_class = head[14:13];
   assign bus.ev_digit = head[12:9];
   assign bus.ev_code = head[8:0];
endmodule
